// File: rtl/jtag_tap_ir_ctrl.sv
`default_nettype none
//============================================================================
// Module      : jtag_tap_ir_ctrl
// Description : 1149.1-style TAP controller with instruction register.
//               Walks the 16-state TAP FSM from tms, captures/shifts/updates
//               the IR, decodes the active instruction into the DR-mux select
//               and retimes the selected serial stream onto tdo.
// Revision    : 1.0 - initial release
//============================================================================
module jtag_tap_ir_ctrl #(
   parameter int                  IR_WIDTH  = 4,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST = '0,
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
   input  logic                tck,
   input  logic                rst,
   input  logic                tms,
   input  logic                tdi,
   input  logic                dr,
   output logic                sel,
   output logic                capture_dr,
   output logic                shift_dr,
   output logic                update_dr,
   output logic [IR_WIDTH-1:0] ir_out,
   output logic [3:0]          state,
   output logic                tdo,
   output logic                tdo_en
);

   // Value parallel-loaded into the IR shifter in Capture-IR (LSBs = 2'b01)
   localparam logic [IR_WIDTH-1:0] C_IR_CAPTURE = IR_WIDTH'(2'b01);

   typedef enum logic [3:0] {
      TLR    = 4'd0,
      RTI    = 4'd1,
      SEL_DR = 4'd2,
      CAP_DR = 4'd3,
      SH_DR  = 4'd4,
      EX1_DR = 4'd5,
      PA_DR  = 4'd6,
      EX2_DR = 4'd7,
      UPD_DR = 4'd8,
      SEL_IR = 4'd9,
      CAP_IR = 4'd10,
      SH_IR  = 4'd11,
      EX1_IR = 4'd12,
      PA_IR  = 4'd13,
      EX2_IR = 4'd14,
      UPD_IR = 4'd15
   } tap_state_t;

   tap_state_t          r_state;
   tap_state_t          w_next_state;
   logic                r_capture_dr;
   logic                r_shift_dr;
   logic                r_update_dr;
   logic [IR_WIDTH-1:0] r_ir_shift;
   logic [IR_WIDTH-1:0] r_ir_out;
   logic [IR_WIDTH-1:0] w_ir_out_next;
   logic                r_sel;
   logic                r_tdo;
   logic                r_tdo_en;

   // Standard TAP transition table; the IR column mirrors the DR column
   function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
      tap_state_t n;
      n = TLR;
      case (s)
         TLR    : n = t ? TLR    : RTI;
         RTI    : n = t ? SEL_DR : RTI;
         SEL_DR : n = t ? SEL_IR : CAP_DR;
         CAP_DR : n = t ? EX1_DR : SH_DR;
         SH_DR  : n = t ? EX1_DR : SH_DR;
         EX1_DR : n = t ? UPD_DR : PA_DR;
         PA_DR  : n = t ? EX2_DR : PA_DR;
         EX2_DR : n = t ? UPD_DR : SH_DR;
         UPD_DR : n = t ? SEL_DR : RTI;
         SEL_IR : n = t ? TLR    : CAP_IR;
         CAP_IR : n = t ? EX1_IR : SH_IR;
         SH_IR  : n = t ? EX1_IR : SH_IR;
         EX1_IR : n = t ? UPD_IR : PA_IR;
         PA_IR  : n = t ? EX2_IR : PA_IR;
         EX2_IR : n = t ? UPD_IR : SH_IR;
         UPD_IR : n = t ? SEL_DR : RTI;
         default: n = TLR;
      endcase
      return n;
   endfunction

   // Only EXTEST and SAMPLE route the boundary-scan chain; anything else is bypass
   function automatic logic decode_sel(input logic [IR_WIDTH-1:0] ir);
      return !((ir == OP_EXTEST) || (ir == OP_SAMPLE));
   endfunction

   // Next-state and next-instruction logic shared by the registered outputs
   always_comb begin
      w_next_state  = tap_next(r_state, tms);
      w_ir_out_next = r_ir_out;
      if (r_state == TLR) begin
         w_ir_out_next = OP_BYPASS;
      end else if (r_state == UPD_IR) begin
         w_ir_out_next = r_ir_shift;
      end
   end

   // TAP FSM; DR strobes are registered from the next state so they track
   // the state code exactly and cannot glitch on multi-bit state changes
   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         r_state      <= TLR;
         r_capture_dr <= 1'b0;
         r_shift_dr   <= 1'b0;
         r_update_dr  <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_capture_dr <= (w_next_state == CAP_DR);
         r_shift_dr   <= (w_next_state == SH_DR);
         r_update_dr  <= (w_next_state == UPD_DR);
      end
   end

   // IR shifter: capture fixed pattern, shift LSB first, otherwise hold
   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         r_ir_shift <= '0;
      end else if (r_state == CAP_IR) begin
         r_ir_shift <= C_IR_CAPTURE;
      end else if (r_state == SH_IR) begin
         r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
      end
   end

   // Active instruction and its DR select; both change only in TLR / Update-IR
   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         r_ir_out <= OP_BYPASS;
         r_sel    <= 1'b1;
      end else begin
         r_ir_out <= w_ir_out_next;
         r_sel    <= decode_sel(w_ir_out_next);
      end
   end

   // Serial output retiming: one TCK of latency from the selected register
   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else begin
         r_tdo    <= (r_state == SH_IR) ? r_ir_shift[0] :
                     (r_state == SH_DR) ? dr : 1'b0;
         r_tdo_en <= (r_state == SH_IR) || (r_state == SH_DR);
      end
   end

   assign state      = r_state;
   assign capture_dr = r_capture_dr;
   assign shift_dr   = r_shift_dr;
   assign update_dr  = r_update_dr;
   assign ir_out     = r_ir_out;
   assign sel        = r_sel;
   assign tdo        = r_tdo;
   assign tdo_en     = r_tdo_en;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ir_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_jtag_tap_ir_ctrl
// Description : Directed, table-driven bench for jtag_tap_ir_ctrl.
// Revision    : 1.0 - initial release
//============================================================================
module tb_jtag_tap_ir_ctrl;

   logic       tck;
   logic       rst;
   logic       tms;
   logic       tdi;
   logic       dr;
   logic       sel;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic [3:0] ir_out;
   logic [3:0] state;
   logic       tdo;
   logic       tdo_en;

   int n_checks;
   int n_fail;

   typedef struct {
      logic       tms;
      logic       tdi;
      logic       dr;
      logic [3:0] st;
      logic [3:0] ir;
      logic       sel;
      logic       tdo;
      logic       en;
   } vec_t;

   vec_t vecs[$];

   jtag_tap_ir_ctrl #(
      .IR_WIDTH (4),
      .OP_EXTEST(4'b0000),
      .OP_SAMPLE(4'b0001),
      .OP_BYPASS(4'b1111)
   ) dut (
      .tck       (tck),
      .rst       (rst),
      .tms       (tms),
      .tdi       (tdi),
      .dr        (dr),
      .sel       (sel),
      .capture_dr(capture_dr),
      .shift_dr  (shift_dr),
      .update_dr (update_dr),
      .ir_out    (ir_out),
      .state     (state),
      .tdo       (tdo),
      .tdo_en    (tdo_en)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic t, input logic d, input logic r, input logic [3:0] st,
                      input logic [3:0] ir, input logic s, input logic o, input logic e);
      vec_t v;
      v.tms = t; v.tdi = d; v.dr = r; v.st = st;
      v.ir = ir; v.sel = s; v.tdo = o; v.en = e;
      vecs.push_back(v);
   endtask

   // One TCK: drive on the falling edge, return 1 time unit after the rising edge
   task automatic step(input logic t, input logic d, input logic r);
      @(negedge tck);
      tms = t; tdi = d; dr = r;
      @(posedge tck);
      #1;
   endtask

   initial begin
      logic [7:0] path_bits [16];
      int         path_len  [16];

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; tms = 1'b1; tdi = 1'b0; dr = 1'b0;

      // Sequence: load EXTEST (TDO 1,0,0,0), DR shift, load BYPASS, DR 1,0,1,
      // load 0x5 with a 3-cycle Pause-IR, load SAMPLE, then TLR forces BYPASS
      //   tms tdi dr  st   ir  sel tdo en
      add(0, 0, 0,  1, 4'hF, 1, 0, 0);
      add(1, 0, 0,  2, 4'hF, 1, 0, 0);
      add(1, 0, 0,  9, 4'hF, 1, 0, 0);
      add(0, 0, 0, 10, 4'hF, 1, 0, 0);
      add(0, 0, 0, 11, 4'hF, 1, 0, 0);
      add(0, 0, 0, 11, 4'hF, 1, 1, 1);
      add(0, 0, 0, 11, 4'hF, 1, 0, 1);
      add(0, 0, 0, 11, 4'hF, 1, 0, 1);
      add(1, 0, 0, 12, 4'hF, 1, 0, 1);
      add(1, 0, 0, 15, 4'hF, 1, 0, 0);
      add(0, 0, 0,  1, 4'h0, 0, 0, 0);
      add(1, 0, 0,  2, 4'h0, 0, 0, 0);
      add(0, 0, 0,  3, 4'h0, 0, 0, 0);
      add(0, 0, 1,  4, 4'h0, 0, 0, 0);
      add(0, 0, 1,  4, 4'h0, 0, 1, 1);
      add(1, 0, 0,  5, 4'h0, 0, 0, 1);
      add(1, 0, 0,  8, 4'h0, 0, 0, 0);
      add(0, 0, 0,  1, 4'h0, 0, 0, 0);
      add(1, 0, 0,  2, 4'h0, 0, 0, 0);
      add(1, 0, 0,  9, 4'h0, 0, 0, 0);
      add(0, 0, 0, 10, 4'h0, 0, 0, 0);
      add(0, 0, 0, 11, 4'h0, 0, 0, 0);
      add(0, 1, 0, 11, 4'h0, 0, 1, 1);
      add(0, 1, 0, 11, 4'h0, 0, 0, 1);
      add(0, 1, 0, 11, 4'h0, 0, 0, 1);
      add(1, 1, 0, 12, 4'h0, 0, 0, 1);
      add(1, 0, 0, 15, 4'h0, 0, 0, 0);
      add(0, 0, 0,  1, 4'hF, 1, 0, 0);
      add(1, 0, 0,  2, 4'hF, 1, 0, 0);
      add(0, 0, 0,  3, 4'hF, 1, 0, 0);
      add(0, 0, 0,  4, 4'hF, 1, 0, 0);
      add(0, 0, 1,  4, 4'hF, 1, 1, 1);
      add(0, 0, 0,  4, 4'hF, 1, 0, 1);
      add(1, 0, 1,  5, 4'hF, 1, 1, 1);
      add(1, 0, 0,  8, 4'hF, 1, 0, 0);
      add(0, 0, 0,  1, 4'hF, 1, 0, 0);
      add(1, 0, 0,  2, 4'hF, 1, 0, 0);
      add(1, 0, 0,  9, 4'hF, 1, 0, 0);
      add(0, 0, 0, 10, 4'hF, 1, 0, 0);
      add(0, 0, 0, 11, 4'hF, 1, 0, 0);
      add(0, 1, 0, 11, 4'hF, 1, 1, 1);
      add(1, 0, 0, 12, 4'hF, 1, 0, 1);
      add(0, 0, 0, 13, 4'hF, 1, 0, 0);
      add(0, 1, 0, 13, 4'hF, 1, 0, 0);
      add(0, 1, 0, 13, 4'hF, 1, 0, 0);
      add(1, 1, 0, 14, 4'hF, 1, 0, 0);
      add(0, 0, 0, 11, 4'hF, 1, 0, 0);
      add(0, 1, 0, 11, 4'hF, 1, 0, 1);
      add(1, 0, 0, 12, 4'hF, 1, 0, 1);
      add(1, 0, 0, 15, 4'hF, 1, 0, 0);
      add(0, 0, 0,  1, 4'h5, 1, 0, 0);
      add(1, 0, 0,  2, 4'h5, 1, 0, 0);
      add(1, 0, 0,  9, 4'h5, 1, 0, 0);
      add(0, 0, 0, 10, 4'h5, 1, 0, 0);
      add(0, 0, 0, 11, 4'h5, 1, 0, 0);
      add(0, 1, 0, 11, 4'h5, 1, 1, 1);
      add(0, 0, 0, 11, 4'h5, 1, 0, 1);
      add(0, 0, 0, 11, 4'h5, 1, 0, 1);
      add(1, 0, 0, 12, 4'h5, 1, 0, 1);
      add(1, 0, 0, 15, 4'h5, 1, 0, 0);
      add(1, 0, 0,  2, 4'h1, 0, 0, 0);
      add(1, 0, 0,  9, 4'h1, 0, 0, 0);
      add(1, 0, 0,  0, 4'h1, 0, 0, 0);
      add(1, 0, 0,  0, 4'hF, 1, 0, 0);

      // TMS paths from TLR to every state, LSB applied first
      path_bits = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                    8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
      path_len  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

      // Reset state, held across a clock edge
      @(posedge tck);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ir", 32'(ir_out), 32'hF);
      chk("rst_sel", 32'(sel), 32'd1);
      chk("rst_tdo", 32'(tdo), 32'd0);
      chk("rst_tdo_en", 32'(tdo_en), 32'd0);
      chk("rst_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'd0);
      @(negedge tck);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].tms, vecs[i].tdi, vecs[i].dr);
         chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
         chk($sformatf("v%0d_ir", i), 32'(ir_out), 32'(vecs[i].ir));
         chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
         chk($sformatf("v%0d_tdo", i), 32'(tdo), 32'(vecs[i].tdo));
         chk($sformatf("v%0d_tdo_en", i), 32'(tdo_en), 32'(vecs[i].en));
         chk($sformatf("v%0d_strobes", i), 32'({capture_dr, shift_dr, update_dr}),
             32'({vecs[i].st == 4'd3, vecs[i].st == 4'd4, vecs[i].st == 4'd8}));
      end

      // Five TMS=1 edges reach TLR from each of the 16 states
      for (int s = 0; s < 16; s++) begin
         logic [7:0] pb;
         pb = path_bits[s];
         for (int k = 0; k < path_len[s]; k++) step(pb[k], 1'b0, 1'b0);
         chk($sformatf("reach_%0d", s), 32'(state), 32'(s));
         for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
         chk($sformatf("tlr_from_%0d", s), 32'(state), 32'd0);
      end

      // Async reset mid Shift-IR: first load EXTEST so the reset is visible
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
      step(1, 0, 0); step(0, 0, 0);
      chk("pre_rst_ir", 32'(ir_out), 32'h0);
      chk("pre_rst_sel", 32'(sel), 32'd0);
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 1, 0);
      chk("pre_rst_state", 32'(state), 32'd11);
      chk("pre_rst_tdo_en", 32'(tdo_en), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_ir", 32'(ir_out), 32'hF);
      chk("async_rst_sel", 32'(sel), 32'd1);
      chk("async_rst_tdo_en", 32'(tdo_en), 32'd0);
      chk("async_rst_tdo", 32'(tdo), 32'd0);
      tms = 1'b0;
      @(posedge tck);
      #1;
      chk("rst_dominates", 32'(state), 32'd0);
      @(negedge tck);
      rst = 1'b0;
      step(0, 0, 0);
      chk("post_rst_state", 32'(state), 32'd1);
      chk("post_rst_ir", 32'(ir_out), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
